ov7670_stream_gen: RTL and testbench

Synthetic OV7670-style pixel source. Reads a 176x144 RGB444 frame from a synchronous frame-buffer read port and replays it as a camera stream, with Vsync, Href and one byte of Data per Pclock at two bytes per pixel. It lets the camera capture path and its colour and shape classification run in simulation or on the board without a sensor. It is the transmitting end of the camera-to-capture interface.

---
 rtl/ov7670_stream_gen.sv | 139 +++++++++++++
 tb/tb_ov7670_stream_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670-style camera source: replays a frame buffer as a
// Vsync/Href/Data byte stream, two bytes per RGB444 pixel.
module ov7670_stream_gen #(
    parameter int H_ACTIVE     = 176,
    parameter int V_ACTIVE     = 144,
    parameter int H_BLANK      = 32,
    parameter int VSYNC_CYCLES = 64,
    parameter int V_BACK       = 16,
    parameter int V_FRONT      = 16
) (
    input  logic        Pclock,
    input  logic        Reset,
    input  logic        Enable,
    output logic [14:0] RAddress,
    input  logic [11:0] RData,
    output logic        Vsync,
    output logic        Href,
    output logic [7:0]  Data,
    output logic        FrameDone
);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        LINE,
        HBLANK,
        VFRONT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic        phase;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [11:0] hold;
    logic [14:0] next_base;
    logic        hold_unused;

    // Only the blue nibble of the held pixel is re-emitted; red/green go out directly.
    assign hold_unused = ^hold[11:4];
    assign next_base   = ({7'd0, y} + 15'd1) * 15'(H_ACTIVE);

    always_comb begin
        next_state = state;
        cnt_next   = cnt + 16'd1;
        case (state)
            IDLE: begin
                cnt_next = 16'd0;
                if (Enable) next_state = VSYNC;
            end
            VSYNC: begin
                if (cnt == 16'(VSYNC_CYCLES - 1)) begin
                    next_state = VBACK;
                    cnt_next   = 16'd0;
                end
            end
            VBACK: begin
                if (cnt == 16'(V_BACK - 1)) begin
                    next_state = LINE;
                    cnt_next   = 16'd0;
                end
            end
            LINE: begin
                cnt_next = 16'd0;
                if (phase && x == 8'(H_ACTIVE - 1))
                    next_state = (y == 8'(V_ACTIVE - 1)) ? VFRONT : HBLANK;
            end
            HBLANK: begin
                if (cnt == 16'(H_BLANK - 1)) begin
                    next_state = LINE;
                    cnt_next   = 16'd0;
                end
            end
            VFRONT: begin
                if (cnt == 16'(V_FRONT - 1)) begin
                    next_state = Enable ? VSYNC : IDLE;
                    cnt_next   = 16'd0;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge Pclock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            phase     <= 1'b0;
            x         <= 8'd0;
            y         <= 8'd0;
            hold      <= 12'h000;
            RAddress  <= 15'd0;
            Vsync     <= 1'b0;
            Href      <= 1'b0;
            Data      <= 8'h00;
            FrameDone <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            Vsync     <= (next_state == VSYNC);
            Href      <= (next_state == LINE);
            FrameDone <= (state == VFRONT) && (next_state == VSYNC);
            Data      <= 8'h00;

            if (next_state == VSYNC && state != VSYNC)
                y <= 8'd0;

            if (next_state == VBACK && state != VBACK)
                RAddress <= {7'd0, y} * 15'(H_ACTIVE);

            // Prefetch the next line start well before its first byte0 edge.
            if (next_state == HBLANK && state == LINE) begin
                y        <= y + 8'd1;
                RAddress <= next_base;
            end

            if (next_state == LINE) begin
                if (state != LINE || phase) begin
                    phase    <= 1'b0;
                    x        <= (state == LINE) ? x + 8'd1 : 8'd0;
                    Data     <= RData[11:4];
                    hold     <= RData;
                    RAddress <= RAddress + 15'd1;
                end else begin
                    phase <= 1'b1;
                    Data  <= {hold[3:0], 4'h0};
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen: a frame-buffer model feeds the
// stream and a byte scoreboard plus edge-timing monitor check what comes out.
module tb_ov7670_stream_gen;

   localparam int H_ACTIVE     = 176;
   localparam int V_ACTIVE     = 4;
   localparam int H_BLANK      = 32;
   localparam int VSYNC_CYCLES = 64;
   localparam int V_BACK       = 16;
   localparam int V_FRONT      = 16;
   localparam int LINE_BYTES   = 2 * H_ACTIVE;
   localparam int FRAME_PERIOD = VSYNC_CYCLES + V_BACK + V_ACTIVE * LINE_BYTES
                                 + (V_ACTIVE - 1) * H_BLANK + V_FRONT;

   logic        Pclock = 1'b0;
   logic        Reset;
   logic        Enable;
   logic [14:0] RAddress;
   logic [11:0] RData;
   logic        Vsync;
   logic        Href;
   logic [7:0]  Data;
   logic        FrameDone;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int mode     = 0;

   ov7670_stream_gen #(
      .H_ACTIVE     (H_ACTIVE),
      .V_ACTIVE     (V_ACTIVE),
      .H_BLANK      (H_BLANK),
      .VSYNC_CYCLES (VSYNC_CYCLES),
      .V_BACK       (V_BACK),
      .V_FRONT      (V_FRONT)
   ) dut (
      .Pclock    (Pclock),
      .Reset     (Reset),
      .Enable    (Enable),
      .RAddress  (RAddress),
      .RData     (RData),
      .Vsync     (Vsync),
      .Href      (Href),
      .Data      (Data),
      .FrameDone (FrameDone)
   );

   // Free-running pixel clock and a cycle counter for interval measurements.
   always #5 Pclock = ~Pclock;
   always @(posedge Pclock) cyc <= cyc + 1;

   // Frame-buffer contents: the address itself, or the address scrambled.
   function automatic logic [11:0] memWord(input int m, input logic [14:0] a);
      return (m == 0) ? a[11:0] : (a[11:0] ^ 12'hA5C);
   endfunction

   // Synchronous read port with one edge of latency.
   always @(posedge Pclock) RData <= memWord(mode, RAddress);

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Drives the control inputs on the inactive edge.
   task automatic applyStimulus(input logic rst, input logic en);
      @(negedge Pclock);
      Reset  = rst;
      Enable = en;
   endtask

   // Scoreboard and timing monitor state.
   logic [7:0] expQ[$];
   int  frameLines = 0;
   int  lineBytes  = 0;
   int  tVsRise = 0, tVsFall = 0, tHrefRise = 0, tHrefFall = 0;
   int  vsRises = 0, hrefRises = 0, fdTotal = 0;
   int  strayFd = 0, badOutside = 0;
   bit  frameStarted = 0, enDropped = 0, prevVs = 0, prevHref = 0;

   // Queue the expected byte stream for a whole frame from the buffer model.
   task automatic pushFrame();
      logic [11:0] w;
      for (int yy = 0; yy < V_ACTIVE; yy++) begin
         for (int xx = 0; xx < H_ACTIVE; xx++) begin
            w = memWord(mode, 15'(yy * H_ACTIVE + xx));
            expQ.push_back(w[11:4]);
            expQ.push_back({w[3:0], 4'h0});
         end
      end
   endtask

   // Samples outputs mid-cycle; checks sync timing and pops scoreboard bytes.
   always @(negedge Pclock) begin
      if (Reset) begin
         expQ.delete();
         frameStarted = 0;
         frameLines   = 0;
         lineBytes    = 0;
         prevVs       = 0;
         prevHref     = 0;
         enDropped    = 0;
      end else begin
         logic [7:0] expByte;
         if (!Href && Data !== 8'h00) badOutside++;
         if (FrameDone === 1'b1) fdTotal++;
         if (FrameDone === 1'b1 && !(Vsync && !prevVs)) strayFd++;

         if (Vsync && !prevVs) begin
            vsRises++;
            if (frameStarted && !enDropped) begin
               checkOutput("lines_per_frame", frameLines, V_ACTIVE);
               checkOutput("vfront_gap", cyc - tHrefFall, V_FRONT);
               checkOutput("frame_period", cyc - tVsRise, FRAME_PERIOD);
               checkOutput("framedone_pulse", FrameDone, 1);
               checkOutput("queue_drained", expQ.size(), 0);
            end else begin
               checkOutput("framedone_quiet", FrameDone, 0);
            end
            expQ.delete();
            pushFrame();
            frameStarted = 1;
            enDropped    = 0;
            frameLines   = 0;
            tVsRise      = cyc;
         end
         if (!Enable) enDropped = 1;

         if (!Vsync && prevVs) begin
            checkOutput("vsync_width", cyc - tVsRise, VSYNC_CYCLES);
            tVsFall = cyc;
         end

         if (Href && !prevHref) begin
            hrefRises++;
            if (frameLines == 0) checkOutput("vback_gap", cyc - tVsFall, V_BACK);
            else                 checkOutput("hblank_gap", cyc - tHrefFall, H_BLANK);
            tHrefRise = cyc;
            lineBytes = 0;
         end

         if (Href) begin
            if (expQ.size() == 0) begin
               checkOutput("stream_bytes_left", expQ.size(), 1);
            end else begin
               expByte = expQ.pop_front();
               checkOutput("stream_byte", Data, expByte);
               if (mode == 0 && frameLines == 2 && (lineBytes == 6 || lineBytes == 7))
                  checkOutput("pixel_3_2", Data, (lineBytes == 6) ? 8'h16 : 8'h30);
            end
            lineBytes++;
         end

         if (!Href && prevHref) begin
            checkOutput("href_width", cyc - tHrefRise, LINE_BYTES);
            tHrefFall = cyc;
            frameLines++;
         end

         prevVs   = Vsync;
         prevHref = Href;
      end
   end

   // Bounded waits on monitor progress; a timeout shows up as a failed check.
   task automatic waitVsRises(input string tag, input int n);
      int budget;
      budget = 3 * FRAME_PERIOD;
      while (vsRises < n && budget > 0) begin
         @(negedge Pclock); #1;
         budget--;
      end
      checkOutput(tag, vsRises >= n, 1);
   endtask

   task automatic waitLines(input string tag, input int n);
      int budget;
      budget = 2 * FRAME_PERIOD;
      while (frameLines < n && budget > 0) begin
         @(negedge Pclock); #1;
         budget--;
      end
      checkOutput(tag, frameLines >= n, 1);
   endtask

   initial begin
      int idleBad;
      int hrefSnap;
      int vsSnap;
      int budget;

      Reset  = 1'b1;
      Enable = 1'b0;
      repeat (3) @(posedge Pclock);
      #1;
      checkOutput("reset_vsync", Vsync, 0);
      checkOutput("reset_href", Href, 0);
      checkOutput("reset_data", Data, 0);
      checkOutput("reset_raddress", RAddress, 0);
      checkOutput("reset_framedone", FrameDone, 0);

      // Released but not enabled: everything must stay quiet.
      applyStimulus(1'b0, 1'b0);
      idleBad = 0;
      repeat (100) begin
         @(negedge Pclock);
         if ({Vsync, Href, FrameDone, Data, RAddress} !== 26'd0) idleBad++;
      end
      checkOutput("idle_quiet", idleBad, 0);

      // Continuous run: Vsync on the first edge that samples Enable.
      applyStimulus(1'b0, 1'b1);
      @(posedge Pclock); #1;
      checkOutput("vsync_on_enable", Vsync, 1);
      waitVsRises("second_frame_start", 2);
      checkOutput("framedone_once", fdTotal, 1);

      // Drop Enable mid-frame; the frame must still complete, then go idle.
      waitLines("reach_line_2", 2);
      applyStimulus(1'b0, 1'b0);
      waitLines("dropped_frame_complete", V_ACTIVE);
      hrefSnap = hrefRises;
      vsSnap   = vsRises;
      repeat (V_FRONT + 100) @(negedge Pclock);
      #1;
      checkOutput("drop_no_new_href", hrefRises, hrefSnap);
      checkOutput("drop_no_new_vsync", vsRises, vsSnap);
      checkOutput("drop_idle_vsync", Vsync, 0);
      checkOutput("drop_queue_drained", expQ.size(), 0);

      // Restart from IDLE with a different buffer pattern.
      @(negedge Pclock);
      mode = 1;
      applyStimulus(1'b0, 1'b1);
      @(posedge Pclock); #1;
      checkOutput("restart_vsync", Vsync, 1);

      // Asynchronous reset in line 1, just after pixel 40 goes out.
      budget = 2 * FRAME_PERIOD;
      do begin
         @(negedge Pclock); #1;
         budget--;
      end while (!(frameLines == 1 && Href && lineBytes == 82) && budget > 0);
      checkOutput("reach_pixel_40", budget > 0, 1);
      #1 Reset = 1'b1;
      #1;
      checkOutput("async_reset_vsync", Vsync, 0);
      checkOutput("async_reset_href", Href, 0);
      checkOutput("async_reset_data", Data, 0);
      checkOutput("async_reset_raddress", RAddress, 0);
      checkOutput("async_reset_framedone", FrameDone, 0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      @(posedge Pclock); #1;
      checkOutput("fresh_vsync_first", Vsync, 1);
      checkOutput("fresh_href_low", Href, 0);

      // Let the fresh frame run to completion, then stop.
      waitLines("fresh_frame_complete", V_ACTIVE);
      applyStimulus(1'b0, 1'b0);
      repeat (V_FRONT + 50) @(negedge Pclock);
      #1;
      checkOutput("final_queue_drained", expQ.size(), 0);
      checkOutput("final_idle_vsync", Vsync, 0);
      checkOutput("stray_framedone", strayFd, 0);
      checkOutput("data_outside_line", badOutside, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
